// File: rtl/lfsr_floor_req_gen.sv
// XNOR-feedback LFSR built from single-bit stages; issues pseudo-random floor-call requests
// over a valid/ready handshake. Define LFSR_SEED_EN to add the seed_load/seed ports.

module lfsr_stage (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module lfsr_floor_req_gen #(
  parameter int WIDTH      = 10,
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               req_ready,
`ifdef LFSR_SEED_EN
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
`endif
  output logic               req_valid,
  output logic [FLOOR_W-1:0] req_floor,
  output logic [WIDTH-1:0]   lfsr_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_OFFER = 2'd2;

  // Bit n-1 set for each tap n; an XNOR LFSR locks up only in the all-ones state.
  function automatic logic [11:0] tap_mask(input int w);
    case (w)
      4:       return 12'h00C;
      5:       return 12'h014;
      6:       return 12'h030;
      7:       return 12'h060;
      8:       return 12'h0B8;
      9:       return 12'h110;
      10:      return 12'h240;
      11:      return 12'h500;
      12:      return 12'h829;
      default: return 12'h000;
    endcase
  endfunction

  localparam logic [11:0]        TAP_ALL  = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0]   TAP_MASK = TAP_ALL[WIDTH-1:0];
  localparam logic [FLOOR_W:0]   NF       = (FLOOR_W + 1)'(NUM_FLOORS);

  if (WIDTH < 4 || WIDTH > 12) begin : g_bad_width
    $error("lfsr_floor_req_gen: WIDTH must be in 4..12");
  end
  if (NUM_FLOORS < 2 || NUM_FLOORS > (1 << FLOOR_W) ||
      NUM_FLOORS <= (1 << (FLOOR_W - 1))) begin : g_bad_floors
    $error("lfsr_floor_req_gen: NUM_FLOORS does not fit FLOOR_W");
  end

  logic [WIDTH-1:0]     lfsr;
  logic [WIDTH-1:0]     shifted;
  logic [WIDTH-1:0]     lfsr_next;
  logic                 fb;
  logic                 stage_en;
  logic [FLOOR_W+3:0]   lfsr_lo;
  logic [FLOOR_W-1:0]   cand;
  logic [FLOOR_W-1:0]   last_floor;
  logic                 last_valid;
  logic [3:0]           gap;
  logic [1:0]           state;

  always_comb begin
    fb      = ~^(lfsr & TAP_MASK);
    shifted = {lfsr[WIDTH-2:0], fb};
  end

`ifdef LFSR_SEED_EN
  // A load takes the place of the shift; an all-ones seed would lock up, so it becomes zero.
  always_comb begin
    stage_en  = enable | seed_load;
    lfsr_next = shifted;
    if (seed_load) begin
      lfsr_next = (&seed) ? '0 : seed;
    end
  end
`else
  always_comb begin
    stage_en  = enable;
    lfsr_next = shifted;
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    lfsr_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (stage_en),
      .d     (lfsr_next[i]),
      .q     (lfsr[i])
    );
  end

  // Narrow LFSRs read the missing floor bits as zero so small widths still elaborate.
  always_comb begin
    lfsr_lo = (FLOOR_W + 4)'(lfsr);
    if ({1'b0, lfsr_lo[FLOOR_W+3:4]} >= NF) begin
      cand = FLOOR_W'({1'b0, lfsr_lo[FLOOR_W+3:4]} - NF);
    end else begin
      cand = lfsr_lo[FLOOR_W+3:4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gap        <= '0;
      req_valid  <= 1'b0;
      req_floor  <= '0;
      last_floor <= '0;
      last_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            gap   <= lfsr_lo[3:0];
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (gap != '0) begin
            gap <= gap - 4'd1;
          end else if (!(last_valid && cand == last_floor)) begin
            req_floor <= cand;
            req_valid <= 1'b1;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (req_valid && req_ready) begin
            req_valid  <= 1'b0;
            last_floor <= req_floor;
            last_valid <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lfsr_out = lfsr;

endmodule

// File: doc/lfsr_floor_req_gen.md
Name: lfsr_floor_req_gen

Overview:
- Chains single-bit register stages into a WIDTH-bit XNOR-feedback LFSR.
- Uses the pseudo-random state to issue randomized floor-call requests to the elevator controller over a valid/ready handshake.
- Sits directly downstream of the one-bit stage flop: it instantiates and consumes those stages, and feeds the request arbiter / controller.
- Used for autonomous demo mode and stress traffic.

Parameters:
- WIDTH, 10, LFSR length in bits; supported 4..12; must be >= FLOOR_W+4.
- NUM_FLOORS, 4, number of floors; must satisfy 2^(FLOOR_W-1) < NUM_FLOORS <= 2^FLOOR_W and NUM_FLOORS >= 2.
- FLOOR_W, 2, width of the floor index.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = LFSR advances and request generation runs.
- req_ready  in  1  consumer accepts req_floor this cycle.
- req_valid  out  1  request pending; registered.
- req_floor  out  FLOOR_W  requested floor, 0..NUM_FLOORS-1; registered.
- lfsr_out  out  WIDTH  current LFSR state (debug/observability).

Interface decision: one clock; reset is synchronous and active-high; ports named clk and reset.

Behaviour:
- Reset values: lfsr=0, req_valid=0, req_floor=0, last_valid=0, state=IDLE, gap counter=0.
- LFSR shift: when enable=1, lfsr <= {lfsr[WIDTH-2:0], fb}; fb = XNOR of tap bits. Tap n means lfsr[n-1].
- Tap set per WIDTH: 4:{4,3} 5:{5,3} 6:{6,5} 7:{7,6} 8:{8,6,5,4} 9:{9,5} 10:{10,7} 11:{11,9} 12:{12,6,4,1}.
- All-ones is the lockup state and is unreachable from reset.
- The LFSR advances every enabled cycle, independent of FSM state and handshake; it holds when enable=0.
- FSM states: IDLE, WAIT, OFFER.
- IDLE: if enable=1, load gap <= lfsr[3:0] and go to WAIT.
- WAIT with enable=0: go to IDLE (abort; no request issued).
- WAIT with gap != 0: gap <= gap-1.
- WAIT with gap == 0: cand = lfsr[FLOOR_W+3:4]; if cand >= NUM_FLOORS then cand -= NUM_FLOORS.
  - If last_valid=1 and cand == last_floor: stay in WAIT with gap=0 and retry next cycle using the new LFSR value.
  - Otherwise: req_floor <= cand, req_valid <= 1, go to OFFER.
- OFFER: req_valid and req_floor held stable until req_valid && req_ready. Enable is ignored here: no retraction.
- On handshake: req_valid <= 0, last_floor <= req_floor, last_valid <= 1, go to IDLE.
- Latency: enable seen in IDLE at cycle t → req_valid=1 at cycle t+gap+2 if no retry. Each retry adds 1 cycle.
- Minimum spacing between accepted requests: 3 cycles (handshake → IDLE → WAIT → OFFER with gap=0).
- req_ready while req_valid=0 is ignored.
- Reset mid-operation (any state, including OFFER) returns every register to its reset value on the next edge. The pending request is dropped.

Optional Feature:
- Macro: LFSR_SEED_EN.
- Defined: adds ports seed_load (in, 1) and seed (in, WIDTH).
  - seed_load=1 loads lfsr <= seed, with priority over shifting, regardless of enable.
  - An all-ones seed is replaced by all-zeros.
  - FSM is unaffected, except that the load cycle does not shift.
- Not defined: ports absent; lfsr leaves zero only by shifting from reset.

Test Plan:
- WIDTH=4, reset then enable=1 → lfsr_out 0x0,0x1,0x3,0x7,0xE,0xD,...; 15-cycle period; 0xF never appears.
- WIDTH=10, enable=1 for 1023 cycles → lfsr_out returns to 0x000 exactly at cycle 1023, never 0x3FF, no earlier repeat.
- Backpressure: req_valid=1 with req_ready=0 for 20 cycles → req_valid and req_floor stable; one-cycle req_ready=1 → req_valid=0 next cycle, last_floor updated.
- req_ready=1 constantly for 1000 handshakes → every req_floor < NUM_FLOORS; no two consecutive requests equal; floors 0..3 all occur.
- enable dropped during WAIT → req_valid stays 0, FSM IDLE, lfsr_out frozen. Enable dropped during OFFER → req_valid held until req_ready.
- reset asserted during OFFER → next cycle req_valid=0, lfsr_out=0. With LFSR_SEED_EN: seed=0x3FF load → lfsr_out=0x000; seed=0x155 → lfsr_out=0x155.
